// File: rtl/jtopl_pg_enc.sv
// Encodes a 17-bit phase increment into the smallest block and its 10-bit fnum.
// The encoder shifts right one bit per cen edge until the value fits in fnum.
module jtopl_pg_enc #(
  parameter int BLKW = 3,
  parameter int FNW  = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            start,
  input  logic [16:0]     phinc,
  output logic            busy,
  output logic            done,
  output logic [BLKW-1:0] block,
  output logic [FNW-1:0]  fnum,
  output logic            exact,
  output logic            sat
);

  localparam int XW = 18;
  localparam logic [BLKW-1:0] BLK_MAX = {BLKW{1'b1}};

  typedef enum logic {IDLE, CALC} state_t;

  state_t          st;
  logic [XW-1:0]   x;
  logic [BLKW-1:0] blk;
  logic            lost;

  // The working value fits once nothing remains above the fnum field.
  function automatic logic fits(input logic [XW-1:0] v);
    return v[XW-1:FNW] == '0;
  endfunction

  // Largest value the fnum field can hold, used when the input is out of range.
  function automatic logic [FNW-1:0] sat_fnum();
    return {FNW{1'b1}};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      x     <= '0;
      blk   <= '0;
      lost  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      block <= '0;
      fnum  <= '0;
      exact <= 1'b0;
      sat   <= 1'b0;
    end else begin
      // done is a single-clk pulse, independent of cen.
      done <= 1'b0;
      if (cen) begin
        case (st)
          IDLE: begin
            if (start) begin
              x    <= {phinc, 1'b0};
              blk  <= '0;
              lost <= 1'b0;
              busy <= 1'b1;
              st   <= CALC;
            end
          end
          CALC: begin
            if (fits(x)) begin
              block <= blk;
              fnum  <= x[FNW-1:0];
              exact <= ~lost;
              sat   <= 1'b0;
              done  <= 1'b1;
              busy  <= 1'b0;
              st    <= IDLE;
            end else if (blk == BLK_MAX) begin
              block <= BLK_MAX;
              fnum  <= sat_fnum();
              exact <= 1'b0;
              sat   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              st    <= IDLE;
            end else begin
              lost <= lost | x[0];
              x    <= x >> 1;
              blk  <= blk + 1'b1;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtopl_pg_enc.sv
// Bench for jtopl_pg_enc: directed cases, cen gating, reset abort and a random sweep.
module tb_jtopl_pg_enc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic        start;
  logic [16:0] phinc;
  logic        busy;
  logic        done;
  logic [2:0]  block;
  logic [9:0]  fnum;
  logic        exact;
  logic        sat;

  int tests = 0;
  int fails = 0;
  int lat;
  bit timed_out;

  jtopl_pg_enc #(.BLKW(3), .FNW(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .start (start),
    .phinc (phinc),
    .busy  (busy),
    .done  (done),
    .block (block),
    .fnum  (fnum),
    .exact (exact),
    .sat   (sat)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: smallest block k with (2*p)>>k <= 1023; beyond block 7 it saturates.
  function automatic void model(input int p, output int b, output int f, output int e, output int s);
    int v;
    v = 2 * p;
    b = 0;
    while (b < 7 && (v >> b) > 1023) b++;
    if ((v >> b) > 1023) begin
      b = 7; f = 1023; e = 0; s = 1;
    end else begin
      f = v >> b;
      e = ((f << b) == v) ? 1 : 0;
      s = 0;
    end
  endfunction

  // One encode: capture on a cen edge, then cen every 'period' clocks until done.
  task automatic run(input logic [16:0] p, input int period, input bit poke, input string tag);
    logic [2:0] b0;
    logic [9:0] f0;
    logic       e0, s0;
    bit         held;
    b0 = block; f0 = fnum; e0 = exact; s0 = sat; held = 1'b1;
    @(negedge clk);
    phinc = p; start = 1'b1; cen = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".busy_up"}, 32'(busy), 1);
    lat = 0;
    timed_out = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = poke && (c == 2);
      phinc = 17'($urandom);
      cen   = ((c % period) == (period - 1));
      @(posedge clk); #1;
      if (cen) lat++;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (block !== b0 || fnum !== f0 || exact !== e0 || sat !== s0) held = 1'b0;
    end
    chk({tag, ".timeout"}, 32'(timed_out), 0);
    chk({tag, ".hold"}, 32'(held), 1);
    chk({tag, ".busy_down"}, 32'(busy), 0);
    @(negedge clk);
    start = 1'b0; cen = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".done_width"}, 32'(done), 0);
  endtask

  task automatic chk_res(input string tag, input int b, input int f, input int e, input int s, input int l);
    chk({tag, ".block"}, 32'(block), b);
    chk({tag, ".fnum"},  32'(fnum),  f);
    chk({tag, ".exact"}, 32'(exact), e);
    chk({tag, ".sat"},   32'(sat),   s);
    chk({tag, ".lat"},   lat,        l);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"},  32'(busy),  0);
    chk({tag, ".done"},  32'(done),  0);
    chk({tag, ".block"}, 32'(block), 0);
    chk({tag, ".fnum"},  32'(fnum),  0);
    chk({tag, ".exact"}, 32'(exact), 0);
    chk({tag, ".sat"},   32'(sat),   0);
  endtask

  initial begin
    int  mb, mf, me, ms, p, rec;
    bit  seen;
    rst_n = 1'b0; cen = 1'b0; start = 1'b0; phinc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero("reset");

    run(17'd100, 1, 1'b0, "p100");
    chk_res("p100", 0, 200, 1, 0, 1);
    run(17'd1000, 1, 1'b0, "p1000");
    chk_res("p1000", 1, 1000, 1, 0, 2);
    run(17'd40000, 1, 1'b0, "p40000");
    chk_res("p40000", 7, 625, 1, 0, 8);
    run(17'd40001, 1, 1'b0, "p40001");
    chk_res("p40001", 7, 625, 0, 0, 8);
    run(17'd70000, 1, 1'b0, "p70000");
    chk_res("p70000", 7, 1023, 0, 1, 8);
    run(17'd65535, 1, 1'b0, "p65535");
    chk_res("p65535", 7, 1023, 0, 0, 8);
    run(17'd0, 1, 1'b0, "p0");
    chk_res("p0", 0, 0, 1, 0, 1);

    // Slow cen with a start pulse while busy: same result, no second encode.
    run(17'd1000, 3, 1'b1, "cen3");
    chk_res("cen3", 1, 1000, 1, 0, 2);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); cen = 1'b1;
      @(posedge clk); #1;
      if (busy || done) seen = 1'b1;
    end
    chk("cen3.no_requeue", 32'(seen), 0);

    // Reset in the middle of an encode.
    @(negedge clk); phinc = 17'd40000; start = 1'b1; cen = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(negedge clk); cen = 1'b1; @(posedge clk); end
    @(negedge clk); rst_n = 1'b0; #1;
    chk_zero("midrst");
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("midrst.no_done", 32'(seen), 0);
    run(17'd40000, 1, 1'b0, "after_rst");
    chk_res("after_rst", 7, 625, 1, 0, 8);

    // Random sweep over the representable range, plus a few out-of-range values.
    for (int i = 0; i < 60; i++) begin
      p = (i < 50) ? int'($urandom_range(0, 65535)) : int'($urandom_range(65536, 131071));
      run(17'(p), (i % 4) + 1, 1'b0, "rnd");
      model(p, mb, mf, me, ms);
      chk_res("rnd", mb, mf, me, ms, ms ? 8 : mb + 1);
      if (p < 65536) begin
        rec = (int'(fnum) << block) >> 1;
        chk("rnd.le", (rec <= p) ? 1 : 0, 1);
        chk("rnd.minimal", (block == 0 || ((2 * p) >> (int'(block) - 1)) > 1023) ? 1 : 0, 1);
        chk("rnd.exact_iff", 32'(exact), (rec == p) ? 1 : 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtopl_pg_enc.md
Name: jtopl_pg_enc

Overview:
- Inverse of the phase-increment calculation in the phase generator: takes a target 17-bit pure phase increment and iteratively encodes it into the block/fnum register pair.
- The result satisfies ((fnum << block) >> 1) ≈ phinc, using the smallest block (maximum fnum precision).
- Sits beside the register interface in the host-side frequency helper path (pitch programming, test benches, auto-tuning logic).
- Runs on the chip clock enable; uses a start/busy/done handshake.

Parameters:
- BLKW, 3, block width; max block = 2^BLKW-1 = 7.
- FNW, 10, fnum width; max fnum = 1023.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; all state advances only on clk edges with cen=1
- start  in  1  request; sampled on cen edges while idle
- phinc  in  17  target phase increment, unsigned; sampled with start
- busy  out  1  high while encoding
- done  out  1  one-clk pulse when the result registers update
- block  out  3  encoded block
- fnum  out  10  encoded fnum
- exact  out  1  re-encoding reproduces phinc bit-exactly
- sat  out  1  phinc not representable; outputs saturated

Behaviour:
- Reset: async on rst_n low. busy=0, done=0, block=0, fnum=0, exact=0, sat=0, state=IDLE. All internal registers are cleared. A reset mid-encode aborts it with no done pulse.
- State IDLE:
  - On a cen edge with start=1: load x = {phinc,1'b0} (18 bits), blk=0, lost=0; set busy=1; go to CALC.
  - start while cen=0 is not captured. start while busy is ignored; there is no queuing.
- State CALC, evaluated on each cen edge:
  - If x[17:10]==0 (fits): block<=blk, fnum<=x[9:0], exact<=~lost, sat<=0, done<=1, busy<=0, go to IDLE.
  - Else if blk==7 (does not fit): block<=7, fnum<=1023, sat<=1, exact<=0, done<=1, busy<=0, go to IDLE.
  - Else: lost<=lost|x[0], x<=x>>1, blk<=blk+1.
- Latency: the result appears k+1 cen edges after the start-capture edge, where k is the final block (k=0..7). The saturated case takes 8 cen edges.
- done:
  - Asserted on the result edge; deasserted on the next clk edge regardless of cen.
  - busy falls on the same edge done rises.
  - start=1 on the first cen edge after done begins a new encode immediately.
- Output holding: block/fnum/exact/sat hold their last result until the next done; they do not change during busy.
- Arithmetic:
  - Truncating shifts; no rounding.
  - phinc < 65536 always fits; phinc >= 65536 always saturates.
  - phinc=0 gives block 0, fnum 0, exact=1.
- cen low for any number of cycles mid-encode: the state freezes; the result is identical to a run with cen tied high.

Test Plan:
- Reset then phinc=100, start, cen=1 -> done after 1 cen edge; block=0, fnum=200, exact=1, sat=0.
- phinc=1000 -> done after 2 cen edges; block=1, fnum=1000, exact=1.
- phinc=40000 -> block=7, fnum=625, exact=1, latency 8. phinc=40001 -> block=7, fnum=625, exact=0.
- phinc=70000 -> block=7, fnum=1023, sat=1, exact=0, latency 8. phinc=65535 -> block=7, fnum=1023, sat=0, exact=0.
- cen toggled 1-in-3 with phinc=1000; second start pulsed while busy -> same result as the tied-high run; second start ignored; exactly one done pulse of one clk.
- rst_n asserted mid-encode of phinc=40000 -> all outputs 0 immediately, no done pulse. Fresh start after release -> normal result.
- Randomised sweep of phinc 0..65535: check ((fnum<<block)>>1) <= phinc, that block is minimal, and exact iff equality holds.
